// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer-side and FIFO-side write bus shared by the arbiter.
// Ports (signals): req, req_data from producers; gnt, accept back to producers;
// data_in, wr_en to the FIFO; full, wr_ack, overflow from the FIFO.
interface fifo_wr_arbiter_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            accept;
    logic [FIFO_WIDTH-1:0]         data_in;
    logic                          wr_en;
    logic                          full;
    logic                          wr_ack;
    logic                          overflow;

    modport master (
        input  req, req_data, full, wr_ack, overflow,
        output gnt, accept, data_in, wr_en
    );

    modport slave (
        output req, req_data, full, wr_ack, overflow,
        input  gnt, accept, data_in, wr_en
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among producers.
// Ports: clk, rst_n (sync active-low); bus (master modport: req/req_data/gnt/accept
// to producers, data_in/wr_en/full/wr_ack/overflow to FIFO); owner_id, busy status;
// err_ack, err_ovf sticky protocol-error flags.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fifo_wr_arbiter_if.master          bus,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       busy,
    output logic                       err_ack,
    output logic                       err_ovf
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state, state_nx;
    logic [NUM_REQ-1:0]   gnt_q, gnt_nx;
    logic [IW-1:0]        owner_nx, rr_ptr, rr_nx, pick;
    logic [3:0]           burst_cnt, burst_nx;
    logic                 exp_ack;
    logic                 own, release_now;

    assign own         = state == OWN;
    assign busy        = own;
    assign bus.gnt     = gnt_q;
    assign bus.wr_en   = own & bus.req[owner_id] & ~bus.full;
    assign bus.accept  = bus.wr_en ? (NUM_REQ'(1) << owner_id) : '0;
    assign bus.data_in = own ? bus.req_data[owner_id*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    // Release when the owner runs dry or the last word of a full burst is taken.
    assign release_now = own & (~bus.req[owner_id] |
                                (bus.wr_en & (burst_cnt == 4'(MAX_BURST - 1))));

    // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req[(int'(rr_ptr) + k) % NUM_REQ])
                pick = IW'((int'(rr_ptr) + k) % NUM_REQ);
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_q;
        owner_nx = owner_id;
        rr_nx    = rr_ptr;
        burst_nx = burst_cnt;
        if (state == IDLE) begin
            if (|bus.req) begin
                state_nx = OWN;
                gnt_nx   = NUM_REQ'(1) << pick;
                owner_nx = pick;
                burst_nx = '0;
            end
        end else if (release_now) begin
            state_nx = IDLE;
            gnt_nx   = '0;
            rr_nx    = (owner_id == IW'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;
        end else if (bus.wr_en) begin
            burst_nx = burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_q     <= '0;
            owner_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            exp_ack   <= 1'b0;
            err_ack   <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            state     <= state_nx;
            gnt_q     <= gnt_nx;
            owner_id  <= owner_nx;
            rr_ptr    <= rr_nx;
            burst_cnt <= burst_nx;
            exp_ack   <= bus.wr_en;
            if (bus.wr_ack != exp_ack)
                err_ack <= 1'b1;
            if (bus.overflow)
                err_ovf <= 1'b1;
        end
    end
endmodule
